// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// ALUOp and ALUControl codes, plus small opcode helper functions.
package multicycle_control_unit_pkg;

    // RV32I subset opcodes handled by the controller
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // FSM states, 4-bit encoding
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    // ALUOp encodings passed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl encodings seen by the datapath ALU
    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    // Immediate format selected purely from the opcode
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        logic [1:0] sel;
        case (op)
            OP_SW:   sel = 2'b01;
            OP_BEQ:  sel = 2'b10;
            OP_JAL:  sel = 2'b11;
            default: sel = 2'b00;
        endcase
        return sel;
    endfunction

    // True for every opcode the FSM knows how to sequence
    function automatic logic is_supported_op(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: ok = 1'b1;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // States that own the shared memory and therefore wait for mem_ready
    function automatic logic is_mem_state(input state_t st);
        logic m;
        case (st)
            S_FETCH, S_MEMREAD, S_MEMWRITE: m = 1'b1;
            default:                        m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU decoder: maps ALUOp plus funct3/funct7 to the ALUControl code.
// Unsupported funct3 values fall back to add without raising a flag.
module alu_decoder
    import multicycle_control_unit_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_opb5,
    output logic [2:0] o_alu_control
);

    // Decode the ALU operation; subtract only for R-type with funct7[5] set
    always_comb begin
        o_alu_control = ALUC_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALUC_ADD;
            ALUOP_SUB: o_alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alu_control = (i_opb5 && i_funct7b5) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  o_alu_control = ALUC_SLT;
                    3'b110:  o_alu_control = ALUC_OR;
                    3'b111:  o_alu_control = ALUC_AND;
                    default: o_alu_control = ALUC_ADD;
                endcase
            end
            default: o_alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: Moore FSM sequencing fetch/decode/execute for an
// RV32I subset over a shared memory, with a mem_ready wait handshake, a
// wait-state watchdog that aborts to a refetch, and an illegal-opcode pulse.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] OP,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic       mem_err
);

    localparam bit                   WDOG_EN = (MEM_TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};
    // Counter value at which the current non-granted cycle is the last allowed one
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [TIMEOUT_W-1:0] r_wait_cnt;
    logic [TIMEOUT_W-1:0] w_wait_cnt_next;
    logic                 w_grant;
    logic                 w_mem_state;
    logic                 w_timeout;
    logic [1:0]           w_alu_op;
    logic [2:0]           w_alu_control;
    logic                 w_unused_funct7;

    // Only funct7[5] matters for this instruction subset
    assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Memory grant and watchdog expiry for the current cycle
    always_comb begin
        w_grant     = MEM_WAIT_EN ? mem_ready : 1'b1;
        w_mem_state = is_mem_state(r_state);
        w_timeout   = WDOG_EN && w_mem_state && !w_grant && (r_wait_cnt == CNT_LAST);
    end

    // Next-state logic; a grant always beats a simultaneous timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    w_next_state = w_grant ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OP)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECR;
                    OP_I:         w_next_state = S_EXECI;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_BEQ:       w_next_state = S_BEQ;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = w_grant ? S_MEMWB : (w_timeout ? S_FETCH : S_MEMREAD);
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = (w_grant || w_timeout) ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_BEQ:      w_next_state = S_FETCH;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Wait counter: counts stalled memory cycles, saturating, cleared on grant/abort/leave
    always_comb begin
        if (w_mem_state && !w_grant && !w_timeout) begin
            w_wait_cnt_next = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : (r_wait_cnt + CNT_ONE);
        end else begin
            w_wait_cnt_next = {TIMEOUT_W{1'b0}};
        end
    end

    // State register and wait counter, asynchronously returned to FETCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= {TIMEOUT_W{1'b0}};
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Moore output decode; FETCH enables and BEQ PCWrite qualified by grant/zero
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        RegWrite   = 1'b0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        w_alu_op   = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = w_grant;
                PCWrite   = w_grant;
                mem_err   = w_timeout;
            end
            S_DECODE: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                illegal_op = !is_supported_op(OP);
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                mem_err = w_timeout;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                mem_err  = w_timeout;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b00;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ResultSrc = 2'b00;
                RegWrite  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b00;
                PCWrite   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b00;
                ResultSrc = 2'b00;
                w_alu_op  = ALUOP_SUB;
                PCWrite   = zero;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

    assign ImmSrc     = imm_src(OP);
    assign ALUControl = w_alu_control;

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7[5]),
        .i_opb5        (OP[5]),
        .o_alu_control (w_alu_control)
    );

endmodule
